sensor_tx_scheduler: RTL and testbench

//  Parametrised scheduler between N sensor controllers and the UART transmitter.
//  - Fair round-robin grant, not a fixed scan.
//  - Captures the granted sensor's word into a local register.
//  - Serialises the word as WORD_W/BYTE_W bytes, MSB byte first.
//  - Pulses data_used to free the sensor buffer.
//  - Optional watchdog on uart_tx_done prevents deadlock when the UART hangs.

---
 rtl/sensor_tx_scheduler_pkg.sv | 23 ++
 rtl/sensor_tx_scheduler_rr_picker.sv | 42 ++++
 rtl/sensor_tx_scheduler.sv | 148 ++++++++++++++
 tb/tb_sensor_tx_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_tx_scheduler_pkg.sv
// +-----------------------------------------------------------------------+
// | sensor_tx_scheduler_pkg                                               |
// | Shared state encoding and default geometry for the sensor scheduler.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package sensor_tx_scheduler_pkg;

    localparam int DEF_N_SENSORS = 8;
    localparam int DEF_WORD_W    = 16;
    localparam int DEF_BYTE_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/sensor_tx_scheduler_rr_picker.sv
// +-----------------------------------------------------------------------+
// | rr_picker                                                             |
// | Combinational round-robin picker: first request after 'last', wrapping.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module rr_picker
    import sensor_tx_scheduler_pkg::*;
#(
    parameter int N  = DEF_N_SENSORS,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          mask,
    input  logic [SW-1:0] last,
    output logic          hit,
    output logic [SW-1:0] idx
);

    int            c;
    logic [SW-1:0] cidx;

    // Walk the rotated order from the far end so the nearest candidate wins.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        c    = 0;
        cidx = '0;
        for (int k = N; k >= 1; k--) begin
            c    = (int'(last) + k) % N;
            cidx = SW'(c);
            if (req[cidx] && !(mask && (cidx == last))) begin
                hit = 1'b1;
                idx = cidx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sensor_tx_scheduler.sv
// +-----------------------------------------------------------------------+
// | sensor_tx_scheduler                                                   |
// | Round-robin sensor word capture and MSB-first byte feed to the UART.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module sensor_tx_scheduler
    import sensor_tx_scheduler_pkg::*;
#(
    parameter int N_SENSORS   = DEF_N_SENSORS,
    parameter int WORD_W      = DEF_WORD_W,
    parameter int BYTE_W      = DEF_BYTE_W,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_SENSORS*WORD_W-1:0]   sensor_bus,
    input  logic [N_SENSORS-1:0]          sensor_ready,
    output logic [N_SENSORS-1:0]          data_used,
    output logic                          uart_tx_en,
    output logic [BYTE_W-1:0]             uart_tx_data,
    input  logic                          uart_tx_done,
    output logic [$clog2(N_SENSORS)-1:0]  sensor_num,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int NB  = WORD_W / BYTE_W;
    localparam int SW  = $clog2(N_SENSORS);
    localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [CW-1:0]      byte_cnt_q, byte_cnt_d;
    logic [WDW-1:0]     wdog_q, wdog_d;
    logic [SW-1:0]      num_q, num_d;
    logic [SW-1:0]      last_q, last_d;
    logic               mask_q;
    logic               terr_q, terr_d;

    logic               pick_hit;
    logic [SW-1:0]      pick_idx;
    logic [WORD_W-1:0]  words [N_SENSORS];

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_unpack
        assign words[i] = sensor_bus[i*WORD_W +: WORD_W];
    end

    // mask_q marks the first IDLE cycle after RELEASE, when the released
    // channel's ready may still be stale.
    rr_picker #(
        .N  (N_SENSORS),
        .SW (SW)
    ) u_picker (
        .req  (sensor_ready),
        .mask (mask_q),
        .last (last_q),
        .hit  (pick_hit),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            wdog_q     <= '0;
            num_q      <= '0;
            last_q     <= SW'(N_SENSORS - 1);
            mask_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            wdog_q     <= wdog_d;
            num_q      <= num_d;
            last_q     <= last_d;
            mask_q     <= (state_q == ST_RELEASE);
            terr_q     <= terr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        wdog_d     = wdog_q;
        num_d      = num_q;
        last_d     = last_q;
        terr_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_hit) begin
                    num_d      = pick_idx;
                    shift_d    = words[pick_idx];
                    byte_cnt_d = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (uart_tx_done) begin
                    if (byte_cnt_q == CW'(NB - 1)) begin
                        state_d = ST_RELEASE;
                    end else begin
                        shift_d    = shift_q << BYTE_W;
                        byte_cnt_d = byte_cnt_q + CW'(1);
                        state_d    = ST_SEND;
                    end
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                    if ((TIMEOUT_CYC > 0) && (wdog_q == WDW'(TIMEOUT_CYC - 1))) begin
                        terr_d  = 1'b1;
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                last_d  = num_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_used = '0;
        if (state_q == ST_RELEASE) begin
            data_used[num_q] = 1'b1;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign uart_tx_en   = (state_q == ST_SEND);
    assign uart_tx_data = ((state_q == ST_SEND) || (state_q == ST_WAIT)) ?
                          shift_q[WORD_W-1 -: BYTE_W] : '0;
    assign sensor_num   = num_q;
    assign timeout_err  = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_sensor_tx_scheduler.sv
// +-----------------------------------------------------------------------+
// | tb_sensor_tx_scheduler                                                |
// | Directed and randomized checks of the scheduler against a word model. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_sensor_tx_scheduler;

    localparam int TO_A = 20;

    logic         clk;
    logic         rst;
    logic         done;
    logic         sel;
    logic [7:0]   rdy;
    logic [23:0]  words [8];

    logic [7:0]   ready_a;
    logic [127:0] bus_a;
    logic [7:0]   du_a;
    logic         en_a, busy_a, terr_a;
    logic [7:0]   data_a;
    logic [2:0]   num_a;

    logic [3:0]   ready_b;
    logic [95:0]  bus_b;
    logic [3:0]   du_b;
    logic         en_b, busy_b, terr_b;
    logic [7:0]   data_b;
    logic [1:0]   num_b;

    int n_tests;
    int n_fail;
    int last;
    int used [8];

    sensor_tx_scheduler #(
        .N_SENSORS(8), .WORD_W(16), .BYTE_W(8), .TIMEOUT_CYC(TO_A)
    ) dut_a (
        .clk(clk), .rst(rst), .sensor_bus(bus_a), .sensor_ready(ready_a),
        .data_used(du_a), .uart_tx_en(en_a), .uart_tx_data(data_a),
        .uart_tx_done(done), .sensor_num(num_a), .busy(busy_a),
        .timeout_err(terr_a)
    );

    sensor_tx_scheduler #(
        .N_SENSORS(4), .WORD_W(24), .BYTE_W(8), .TIMEOUT_CYC(0)
    ) dut_b (
        .clk(clk), .rst(rst), .sensor_bus(bus_b), .sensor_ready(ready_b),
        .data_used(du_b), .uart_tx_en(en_b), .uart_tx_data(data_b),
        .uart_tx_done(done), .sensor_num(num_b), .busy(busy_b),
        .timeout_err(terr_b)
    );

    assign ready_a = sel ? 8'h00 : rdy;
    assign ready_b = sel ? rdy[3:0] : 4'h0;

    always_comb begin
        bus_a = '0;
        bus_b = '0;
        for (int i = 0; i < 8; i++) bus_a[i*16 +: 16] = words[i][15:0];
        for (int i = 0; i < 4; i++) bus_b[i*24 +: 24] = words[i];
    end

    wire [7:0] du_m   = sel ? {4'h0, du_b} : du_a;
    wire       en_m   = sel ? en_b   : en_a;
    wire [7:0] data_m = sel ? data_b : data_a;
    wire [2:0] num_m  = sel ? {1'b0, num_b} : num_a;
    wire       busy_m = sel ? busy_b : busy_a;
    wire       terr_m = sel ? terr_b : terr_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first ready channel strictly after the last grant.
    function automatic int next_ch(input logic [7:0] r, input int lst, input int n);
        for (int k = 1; k <= n; k++) begin
            if (r[(lst + k) % n]) return (lst + k) % n;
        end
        return 0;
    endfunction

    // rel_mode: 0 = buffer frees on data_used, 1 = ready lingers one cycle, 2 = ready held
    task automatic xfer(input int ch, input logic [23:0] word, input int nb, input int dly,
                        input bit hold, input bit to_mode, input int rel_mode,
                        input bit strict, input bit scramble);
        int          cnt;
        logic [7:0]  eb;
        cnt = 0;
        if (hold) done = 1'b1;
        while (!en_m && cnt < 40) begin
            step();
            cnt++;
        end
        chk("en_seen", en_m, 1);
        if (strict) chk("latency", cnt, 1);
        for (int b = 0; b < nb; b++) begin
            eb = 8'(word >> (8 * (nb - 1 - b)));
            chk("en", en_m, 1);
            chk("byte", data_m, eb);
            chk("num", num_m, ch);
            chk("du_send", du_m, 0);
            if (b == 0 && scramble) begin
                words[ch] = 24'($urandom);
                rdy[ch]   = 1'b0;
            end
            step();
            chk("en_pulse", en_m, 0);
            chk("hold", data_m, eb);
            if (to_mode) begin
                cnt = 1;
                while (du_m == 8'h00 && cnt < 60) begin
                    step();
                    cnt++;
                end
                chk("to_lat", cnt, TO_A + 1);
                break;
            end
            for (int d = 1; d < dly; d++) begin
                step();
                chk("wait_hold", data_m, eb);
                chk("wait_en", en_m, 0);
            end
            done = 1'b1;
            step();
            if (!hold) done = 1'b0;
        end
        done = 1'b0;
        chk("du", du_m, 32'(1) << ch);
        chk("terr", terr_m, 32'(to_mode));
        chk("en_rel", en_m, 0);
        chk("data_rel", data_m, 0);
        chk("busy_rel", busy_m, 1);
        last = ch;
        used[ch]++;
        if (rel_mode == 0) rdy[ch] = 1'b0;
        step();
        chk("du_pulse", du_m, 0);
        chk("busy_idle", busy_m, 0);
        chk("terr_pulse", terr_m, 0);
        if (rel_mode == 1) begin
            step();
            chk("stale", en_m, 0);
            rdy[ch] = 1'b0;
            repeat (2) begin
                step();
                chk("stale", en_m, 0);
            end
        end
    endtask

    task automatic rand_stream(input int n, input int nb, input logic [23:0] wm, input int nwords);
        logic [7:0] nmask;
        int         ch;
        bit         hold;
        nmask = 8'((1 << n) - 1);
        for (int i = 0; i < nwords; i++) begin
            for (int c = 0; c < n; c++) begin
                if (!rdy[c] && ($urandom % 3 == 0)) begin
                    words[c] = 24'($urandom) & wm;
                    rdy[c]   = 1'b1;
                end
            end
            if ((rdy & nmask) == 8'h00) begin
                ch        = int'($urandom % n);
                words[ch] = 24'($urandom) & wm;
                rdy[ch]   = 1'b1;
            end
            ch   = next_ch(rdy, last, n);
            hold = ($urandom % 4 == 0);
            xfer(ch, words[ch], nb, hold ? 1 : 1 + int'($urandom % 4), hold, 1'b0, 0,
                 1'b0, 1'($urandom % 2));
        end
        rdy = 8'h00;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sel     = 1'b0;
        rdy     = 8'h00;
        done    = 1'b0;
        rst     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            words[i] = 24'h0;
            used[i]  = 0;
        end
        repeat (3) step();
        rst  = 1'b0;
        last = 7;
        chk("rst_busy", busy_m, 0);
        chk("rst_en", en_m, 0);
        chk("rst_du", du_m, 0);
        chk("rst_data", data_m, 0);
        chk("rst_num", num_m, 0);
        chk("rst_terr", terr_m, 0);

        // Single word on channel 2.
        words[2] = 24'h00A5C3;
        rdy      = 8'h04;
        xfer(2, 24'h00A5C3, 2, 2, 1'b0, 1'b0, 0, 1'b1, 1'b0);

        // Stale ready on channel 5 must not cause a second grant.
        words[5] = 24'($urandom) & 24'h00FFFF;
        rdy      = 8'h20;
        xfer(5, words[5], 2, 1, 1'b0, 1'b0, 1, 1'b1, 1'b0);

        // Fairness with every channel permanently ready.
        for (int i = 0; i < 8; i++) begin
            words[i] = 24'($urandom) & 24'h00FFFF;
            used[i]  = 0;
        end
        rdy = 8'hFF;
        for (int w = 0; w < 9; w++) begin
            xfer(next_ch(rdy, last, 8), words[next_ch(rdy, last, 8)], 2, 3,
                 1'b0, 1'b0, 2, 1'b0, 1'b0);
            if (w == 7) begin
                for (int i = 0; i < 8; i++) chk("fair", used[i], 1);
            end
        end
        rdy = 8'h00;

        // Watchdog: done never arrives.
        words[1] = 24'h00BEEF;
        rdy      = 8'h02;
        xfer(1, 24'h00BEEF, 2, 1, 1'b0, 1'b1, 0, 1'b1, 1'b0);

        rand_stream(8, 2, 24'h00FFFF, 25);

        // Reset during WAIT of byte 0 abandons the word silently.
        words[3] = 24'h001234;
        words[0] = 24'h00ABCD;
        rdy      = 8'h08;
        step();
        chk("t5_en", en_m, 1);
        step();
        rst = 1'b1;
        rdy = 8'h09;
        step();
        rst  = 1'b0;
        last = 7;
        chk("t5_busy", busy_m, 0);
        chk("t5_en0", en_m, 0);
        chk("t5_du", du_m, 0);
        chk("t5_num", num_m, 0);
        xfer(0, 24'h00ABCD, 2, 2, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        xfer(3, 24'h001234, 2, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        rdy = 8'h00;

        // Four channels, three bytes per word.
        sel      = 1'b1;
        last     = 3;
        words[3] = 24'h123456;
        rdy      = 8'h08;
        xfer(3, 24'h123456, 3, 2, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        words[0] = 24'hABCDEF;
        rdy      = 8'h01;
        xfer(0, 24'hABCDEF, 3, 40, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        rand_stream(4, 3, 24'hFFFFFF, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
